// File: rtl/syncgen_param_if.sv
// Raster timing bus between the sync generator and the pixel pipeline.
// The generator side (master) receives the count enable and the genlock
// request and drives the syncs, data enable, counters, coordinates and strobes.
// The consumer side (slave) is the mirror image and is what a testbench or
// the downstream pattern/VGA logic attaches to.
interface syncgen_param_if #(
  parameter int CW = 12
);
  logic          EN;
  logic          RESYNC;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          DE;
  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic [CW-1:0] PX;
  logic [CW-1:0] PY;
  logic          LINE_START;
  logic          FRAME_START;

  modport master (
    input  EN,
    input  RESYNC,
    output VGA_HS,
    output VGA_VS,
    output DE,
    output HCNT,
    output VCNT,
    output PX,
    output PY,
    output LINE_START,
    output FRAME_START
  );

  modport slave (
    output EN,
    output RESYNC,
    input  VGA_HS,
    input  VGA_VS,
    input  DE,
    input  HCNT,
    input  VCNT,
    input  PX,
    input  PY,
    input  LINE_START,
    input  FRAME_START
  );
endinterface

// File: rtl/syncgen_param.sv
// Parametrised raster sync generator.
// Produces horizontal/vertical position counters, polarity-configurable sync
// pulses, a data enable, active-area coordinates and line/frame start strobes.
// Every output is a register decoded from the *next* counter value, so all
// outputs line up with the HCNT/VCNT they describe with no pipeline skew.
// A count enable freezes the whole block; a genlock request forces the next
// horizontal wrap to start a new frame.
module syncgen_param #(
  parameter int CW      = 12,
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSW     = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSW     = 2,
  parameter int VBP     = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input logic            CLK,
  input logic            RST,
  syncgen_param_if.master bus
);

  localparam int HPERIOD = HACTIVE + HFP + HSW + HBP;
  localparam int VPERIOD = VACTIVE + VFP + VSW + VBP;

  // Both periods must be representable as CW-bit unsigned values, otherwise
  // the wrap comparisons below would silently alias.
  if (HPERIOD >= (1 << CW)) begin : g_hperiod_too_wide
    $error("syncgen_param: HPERIOD does not fit in CW bits");
  end
  if (VPERIOD >= (1 << CW)) begin : g_vperiod_too_wide
    $error("syncgen_param: VPERIOD does not fit in CW bits");
  end

  // All timing landmarks as CW-bit constants so every compare is unsigned CW-bit.
  localparam logic [CW-1:0] H_LAST   = CW'(HPERIOD - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VPERIOD - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(HACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(VACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] HS_STOP  = CW'(HACTIVE + HFP + HSW);
  localparam logic [CW-1:0] VS_START = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] VS_STOP  = CW'(VACTIVE + VFP + VSW);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic          HS_IDLE  = ~HS_POL;
  localparam logic          VS_IDLE  = ~VS_POL;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          restart;
  logic          resync_pend;

  logic          hs_on;
  logic          vs_on;
  logic          de_nxt;

  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic [CW-1:0] px_q;
  logic [CW-1:0] py_q;
  logic          line_q;
  logic          frame_q;

  // Next raster position: a pending or same-cycle genlock request turns the
  // horizontal wrap into a frame restart; HCNT itself is never disturbed.
  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    restart = resync_pend | bus.RESYNC;
    h_nxt   = h_wrap ? '0 : h_cnt + ONE;
    v_nxt   = v_cnt;
    if (h_wrap) begin
      if (restart || (v_cnt == V_LAST)) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + ONE;
      end
    end
  end

  // Decode of the position the counters are about to show; VS only depends on
  // the line number, which only moves at a wrap, so VS only changes at h==0.
  always_comb begin
    hs_on  = (h_nxt >= HS_START) && (h_nxt < HS_STOP);
    vs_on  = (v_nxt >= VS_START) && (v_nxt < VS_STOP);
    de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  end

  // Position counters: reset parks on the last (blanking) pixel of the frame
  // so the first enabled cycle lands on 0/0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (bus.EN) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Genlock pending flag: captured even while frozen, consumed by the next
  // enabled wrap (which also absorbs a request arriving on that same edge).
  always_ff @(posedge CLK) begin
    if (RST) begin
      resync_pend <= 1'b0;
    end else if (bus.EN && h_wrap) begin
      resync_pend <= 1'b0;
    end else if (bus.RESYNC) begin
      resync_pend <= 1'b1;
    end
  end

  // Registered outputs: levels hold while frozen, strobes only fire on the
  // enabled cycle that enters a new line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q    <= HS_IDLE;
      vs_q    <= VS_IDLE;
      de_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (bus.EN) begin
        hs_q    <= hs_on ? HS_POL : HS_IDLE;
        vs_q    <= vs_on ? VS_POL : VS_IDLE;
        de_q    <= de_nxt;
        px_q    <= de_nxt ? h_nxt : '0;
        py_q    <= de_nxt ? v_nxt : '0;
        line_q  <= (h_nxt == '0);
        frame_q <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.DE          = de_q;
  assign bus.HCNT        = h_cnt;
  assign bus.VCNT        = v_cnt;
  assign bus.PX          = px_q;
  assign bus.PY          = py_q;
  assign bus.LINE_START  = line_q;
  assign bus.FRAME_START = frame_q;

endmodule

// File: tb/tb_syncgen_param.sv
// Testbench for syncgen_param: a default-timing instance and a tiny
// positive-polarity instance run side by side. A reference model walks a
// linear pixel index through the frame; each stimulus cycle pushes the
// expected outputs into a per-instance queue, and a monitor pops and compares
// after every clock edge.
module tb_syncgen_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s = 2'b11;
  logic [1:0] en_s  = 2'b00;
  logic [1:0] rs_s  = 2'b00;

  syncgen_param_if #(.CW(12)) if0 ();
  syncgen_param_if #(.CW(12)) if1 ();

  assign if0.EN     = en_s[0];
  assign if0.RESYNC = rs_s[0];
  assign if1.EN     = en_s[1];
  assign if1.RESYNC = rs_s[1];

  syncgen_param dut0 (
    .CLK (clk),
    .RST (rst_s[0]),
    .bus (if0)
  );

  syncgen_param #(
    .CW(12), .HACTIVE(4), .HFP(1), .HSW(2), .HBP(1),
    .VACTIVE(3), .VFP(1), .VSW(1), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut1 (
    .CLK (clk),
    .RST (rst_s[1]),
    .bus (if1)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic [11:0] px;
    logic [11:0] py;
  } obs_t;

  typedef struct {
    int hact, hfp, hsw, hbp;
    int vact, vfp, vsw, vbp;
    bit hpol, vpol;
  } cfg_t;

  obs_t obs [2];
  assign obs[0] = {if0.VGA_HS, if0.VGA_VS, if0.DE, if0.LINE_START, if0.FRAME_START,
                   if0.HCNT, if0.VCNT, if0.PX, if0.PY};
  assign obs[1] = {if1.VGA_HS, if1.VGA_VS, if1.DE, if1.LINE_START, if1.FRAME_START,
                   if1.HCNT, if1.VCNT, if1.PX, if1.PY};

  cfg_t cfg [2];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   fr_on  = 1'b0;

  int   idx      [2];
  bit   pend     [2];
  obs_t last_exp [2];
  obs_t q0 [$];
  obs_t q1 [$];

  function automatic int hper(int k);
    return cfg[k].hact + cfg[k].hfp + cfg[k].hsw + cfg[k].hbp;
  endfunction

  function automatic int vper(int k);
    return cfg[k].vact + cfg[k].vfp + cfg[k].vsw + cfg[k].vbp;
  endfunction

  // Expected outputs for linear pixel index i of instance k.
  function automatic obs_t decode(int k, int i, bit ls, bit fs);
    obs_t d;
    int h, v, hs0, vs0;
    h   = i % hper(k);
    v   = i / hper(k);
    hs0 = cfg[k].hact + cfg[k].hfp;
    vs0 = cfg[k].vact + cfg[k].vfp;
    d.hs   = (h >= hs0 && h < hs0 + cfg[k].hsw) ? cfg[k].hpol : ~cfg[k].hpol;
    d.vs   = (v >= vs0 && v < vs0 + cfg[k].vsw) ? cfg[k].vpol : ~cfg[k].vpol;
    d.de   = (h < cfg[k].hact) && (v < cfg[k].vact);
    d.hcnt = 12'(h);
    d.vcnt = 12'(v);
    d.px   = d.de ? 12'(h) : 12'd0;
    d.py   = d.de ? 12'(v) : 12'd0;
    d.ls   = ls;
    d.fs   = fs;
    return d;
  endfunction

  // Reference model: advance one clock with the inputs about to be sampled.
  task automatic model_step(int k);
    obs_t e;
    int hp, n, h;
    hp = hper(k);
    n  = hp * vper(k);
    if (rst_s[k]) begin
      idx[k]  = n - 1;
      pend[k] = 1'b0;
      e       = '0;
      e.hs    = ~cfg[k].hpol;
      e.vs    = ~cfg[k].vpol;
      e.hcnt  = 12'(hp - 1);
      e.vcnt  = 12'(vper(k) - 1);
    end else if (en_s[k]) begin
      h = idx[k] % hp;
      if (h == hp - 1) begin
        idx[k]  = (pend[k] || rs_s[k]) ? 0 : (idx[k] + 1) % n;
        pend[k] = 1'b0;
      end else begin
        idx[k]  = idx[k] + 1;
        pend[k] = pend[k] | rs_s[k];
      end
      e = decode(k, idx[k], (idx[k] % hp) == 0, idx[k] == 0);
    end else begin
      pend[k] = pend[k] | rs_s[k];
      e       = last_exp[k];
      e.ls    = 1'b0;
      e.fs    = 1'b0;
    end
    last_exp[k] = e;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic apply_stimulus(int n);
    repeat (n) begin
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_h(int k, int h);
    int guard;
    guard = 0;
    while ((idx[k] % hper(k)) != h && guard < 2000) begin
      apply_stimulus(1);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_h inst%0d: position %0d not reached, at %0d", k, h, idx[k] % hper(k));
    end
  endtask

  task automatic check_output(int k);
    obs_t e;
    checks++;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      errors++;
      $display("[TB] FAIL scoreboard inst%0d cyc %0d: no expectation queued", k, cyc);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    if (obs[k] !== e) begin
      errors++;
      $display("[TB] FAIL outputs inst%0d cyc %0d got hs%b vs%b de%b ls%b fs%b h%0d v%0d px%0d py%0d required hs%b vs%b de%b ls%b fs%b h%0d v%0d px%0d py%0d",
               k, cyc, obs[k].hs, obs[k].vs, obs[k].de, obs[k].ls, obs[k].fs,
               obs[k].hcnt, obs[k].vcnt, obs[k].px, obs[k].py,
               e.hs, e.vs, e.de, e.ls, e.fs, e.hcnt, e.vcnt, e.px, e.py);
    end
  endtask

  int last_fs1 = -1;
  int last_ls0 = -1;
  int de_cnt   = 0;
  logic prev_hs0 = 1'b1;

  // Free-running frame statistics, measured from the DUT outputs themselves.
  task automatic free_run_check();
    if (!fr_on) begin
      last_fs1 = -1;
      last_ls0 = -1;
      de_cnt   = 0;
      prev_hs0 = 1'b1;
      return;
    end
    if (obs[1].fs) begin
      if (last_fs1 >= 0) begin
        checks++;
        if (cyc - last_fs1 != hper(1) * vper(1)) begin
          errors++;
          $display("[TB] FAIL frame_period got %0d required %0d", cyc - last_fs1, hper(1) * vper(1));
        end
        checks++;
        if (de_cnt != cfg[1].hact * cfg[1].vact) begin
          errors++;
          $display("[TB] FAIL de_per_frame got %0d required %0d", de_cnt, cfg[1].hact * cfg[1].vact);
        end
      end
      last_fs1 = cyc;
      de_cnt   = 0;
    end
    if (obs[1].de) de_cnt++;
    if (obs[0].ls) begin
      if (last_ls0 >= 0) begin
        checks++;
        if (cyc - last_ls0 != 800) begin
          errors++;
          $display("[TB] FAIL line_period got %0d required 800", cyc - last_ls0);
        end
      end
      last_ls0 = cyc;
    end
    if (prev_hs0 == 1'b1 && obs[0].hs == 1'b0) begin
      checks++;
      if (obs[0].hcnt != 12'd656) begin
        errors++;
        $display("[TB] FAIL hs_start got %0d required 656", obs[0].hcnt);
      end
    end
    prev_hs0 = obs[0].hs;
  endtask

  // Monitor: compare every instance after each clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check_output(0);
      check_output(1);
      free_run_check();
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    idx[0] = 0; idx[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_exp[0] = '0; last_exp[1] = '0;

    // Reset, then a 10-cycle stall parked on the last pixel of the frame.
    rst_s = 2'b11; en_s = 2'b11; rs_s = 2'b00;
    apply_stimulus(2);
    rst_s = 2'b00; en_s = 2'b00;
    apply_stimulus(10);
    en_s = 2'b11;
    apply_stimulus(900);

    // Genlock mid-line, then a request landing exactly on a wrap.
    wait_h(0, 100);
    rs_s = 2'b01;
    apply_stimulus(1);
    rs_s = 2'b00;
    wait_h(0, 799);
    apply_stimulus(1);
    wait_h(0, 799);
    rs_s = 2'b01;
    apply_stimulus(1);
    rs_s = 2'b00;
    wait_h(1, 2);
    rs_s = 2'b10;
    apply_stimulus(1);
    rs_s = 2'b00;
    wait_h(1, 7);
    rs_s = 2'b10;
    apply_stimulus(1);
    rs_s = 2'b00;

    // Reset mid-frame while a genlock request is pending.
    wait_h(0, 300);
    rs_s = 2'b11;
    apply_stimulus(1);
    rs_s = 2'b00;
    apply_stimulus(3);
    rst_s = 2'b11;
    apply_stimulus(1);
    rst_s = 2'b00;
    apply_stimulus(2);

    // Randomised enable / genlock / reset traffic.
    for (int i = 0; i < 6000; i++) begin
      for (int k = 0; k < 2; k++) begin
        en_s[k]  = ($urandom_range(0, 9) != 0);
        rs_s[k]  = ($urandom_range(0, 39) == 0);
        rst_s[k] = ($urandom_range(0, 499) == 0);
      end
      apply_stimulus(1);
    end

    // Free run from reset for frame statistics.
    rst_s = 2'b11; en_s = 2'b11; rs_s = 2'b00;
    apply_stimulus(1);
    rst_s = 2'b00;
    fr_on = 1'b1;
    apply_stimulus(1700);
    fr_on = 1'b0;
    apply_stimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syncgen_param.md
Name: syncgen_param

Overview:
- Parametrised successor to the fixed 640x480 sync generator.
- Generates horizontal and vertical counters, sync pulses with configurable polarity, a data-enable signal, active-area pixel coordinates, and line/frame start strobes for any raster timing.
- Adds a count enable and a genlock resync request.
- Sits between the pixel clock source and the pixel pattern/VGA output logic; the pixel clock is supplied from outside on CLK.

Parameters:
- CW, 12, width of all counters and coordinate outputs
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSW, 96, horizontal sync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VACTIVE, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSW, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- HS_POL, 0, active level of VGA_HS
- VS_POL, 0, active level of VGA_VS

Ports:
- CLK  in  1  pixel clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  count enable; low freezes the whole block
- RESYNC  in  1  genlock request pulse; restarts the frame at the next line boundary
- VGA_HS  out  1  horizontal sync, active level HS_POL
- VGA_VS  out  1  vertical sync, active level VS_POL
- DE  out  1  high inside the active area
- HCNT  out  CW  horizontal position, 0..HPERIOD-1
- VCNT  out  CW  vertical position, 0..VPERIOD-1
- PX  out  CW  active-area x (HCNT while DE, else 0)
- PY  out  CW  active-area y (VCNT while DE, else 0)
- LINE_START  out  1  one-cycle strobe at HCNT==0
- FRAME_START  out  1  one-cycle strobe at HCNT==0 and VCNT==0

Behaviour:
- Derived periods: HPERIOD = HACTIVE+HFP+HSW+HBP; VPERIOD = VACTIVE+VFP+VSW+VBP. Both must fit in CW bits; an elaboration-time check fails otherwise.
- Every output is a register. Each is decoded from the next counter value, so it is cycle-aligned with the HCNT/VCNT it describes (zero skew).
- Decode for a position (h,v):
  - HS is active iff HACTIVE+HFP <= h < HACTIVE+HFP+HSW.
  - VS is active iff VACTIVE+VFP <= v < VACTIVE+VFP+VSW, for the whole line; VS changes only at h==0.
  - DE = (h<HACTIVE) && (v<VACTIVE).
- Reset (RST high at a CLK edge):
  - HCNT=HPERIOD-1, VCNT=VPERIOD-1; the last pixel of the frame is blanking.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, DE=0, PX=PY=0, LINE_START=FRAME_START=0.
  - The resync-pending flag is cleared.
  - The first enabled cycle after reset shows HCNT=0, VCNT=0, DE=1, LINE_START=1, FRAME_START=1.
- Counting (EN=1):
  - HCNT increments and wraps HPERIOD-1 -> 0.
  - At the wrap, VCNT increments and wraps VPERIOD-1 -> 0.
- EN=0:
  - Counters, syncs, DE, PX and PY hold their values.
  - LINE_START and FRAME_START are forced to 0.
  - When EN returns, counting continues from the held position. Strobes fire only on the enabled cycle that enters h==0.
- RESYNC:
  - Sampled when RST=0, regardless of EN. Sets a pending flag.
  - At the next enabled horizontal wrap, VCNT goes to 0 instead of incrementing, and the flag clears.
  - A RESYNC asserted in the same cycle as the wrap edge applies at that wrap.
  - Multiple RESYNC pulses before a wrap merge into one.
  - A RESYNC on the natural VPERIOD-1 -> 0 wrap has no extra effect.
  - HCNT is never disturbed by RESYNC.
- Reset mid-frame: reset dominates EN and RESYNC and returns the block to the reset state in the same edge.
- Arithmetic: all comparisons use CW-bit unsigned values; no other wrap-around is permitted.

Test Plan:
- Default parameters, EN=1, run 2 frames from reset:
  - HS active (low) for HCNT 656..751.
  - VS low for VCNT 490..491.
  - DE count = 307200 per frame.
  - FRAME_START exactly every 420000 cycles.
  - LINE_START every 800 cycles.
- HS_POL=1, VS_POL=1, HACTIVE=4, HFP=1, HSW=2, HBP=1, VACTIVE=3, VFP=1, VSW=1, VBP=1:
  - HS high exactly at HCNT 5..6.
  - VS high on VCNT 4.
  - PX runs 0..3 then 0; PY runs 0..2.
- Drop EN for 10 cycles at HCNT=799, VCNT=524:
  - Outputs hold, with no strobe during the stall.
  - On the first enabled cycle: HCNT=0, VCNT=0, FRAME_START=1.
- Pulse RESYNC at HCNT=100, VCNT=200:
  - At the next wrap VCNT=0 and FRAME_START=1.
  - A second RESYNC pulse arriving on the wrap cycle itself also restarts at that wrap.
- Assert RST for 1 cycle at HCNT=300, VCNT=100 with RESYNC pending:
  - Next cycle shows HCNT=799, VCNT=524, syncs inactive, DE=0.
  - The cycle after shows 0/0 with FRAME_START=1; the pending resync is discarded.
